cm_arb_key: RTL and testbench
=============================

# cm_arb_key

Keyed arbiter that shares one valid/ready output channel between `REQ_CNT` requesters. Each cycle it picks the valid requester with the minimum or maximum key, selected by the `cm_pkg::t_arb_algo` parameter. Ties are broken round-robin. The winning beat is registered into a single output slot. It sits in front of shared `lib_cm` datapaths and resources wherever several producers compete for one consumer.

## Interface
- `REQ_CNT`, 4: number of requesters; must be ≥ 2.
- `KEY_W`, 8: key width; keys are unsigned.
- `DATA_W`, 32: payload width.
- `ARB_ALGO`, `cm_pkg::ARB_MIN`: `ARB_MIN` grants the smallest key; `ARB_MAX` grants the largest key.
- `IDX_W` (derived, not overridable): `$clog2(REQ_CNT)`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `i_req_vld` in `REQ_CNT`: per-requester valid.
- `i_req_key` in `REQ_CNT` × `KEY_W`: per-requester key.
- `i_req_data` in `REQ_CNT` × `DATA_W`: per-requester payload.
- `o_req_rdy` out `REQ_CNT`: per-requester ready; one-hot or zero.
- `o_vld` out 1: output valid.
- `o_data` out `DATA_W`: granted payload.
- `o_idx` out `IDX_W`: index of the granted requester.
- `i_rdy` in 1: downstream ready.

## Operation
**Output slot**
- One output register holds `o_vld`, `o_data` and `o_idx` (and `o_last` when the packet-lock feature below is compiled in).
- `load = !o_vld | i_rdy`. The slot accepts a new beat when it is empty or is being drained in the same cycle.

**Arbitration** (combinational, only when `load = 1`)
- Candidates are the requesters with `i_req_vld[i] = 1`.
- Winner: the candidate with the minimum key (`ARB_MIN`) or maximum key (`ARB_MAX`).
- Among equal best keys, the winner is the first index found scanning upward from `ptr` with wrap-around (`ptr`, `ptr+1`, …, `REQ_CNT-1`, 0, …).
- `o_req_rdy[winner] = 1` in the same cycle. All other ready bits are 0.
- If there are no candidates, or `load = 0`, all `o_req_rdy` bits are 0.

**Round-robin pointer** `ptr` (`IDX_W` bits)
- On every grant: `ptr <= (winner == REQ_CNT-1) ? 0 : winner + 1`.
- When there is no grant, `ptr` holds its value.

**Slot update**
- Grant: slot loads the winner's data and index; `o_vld <= 1`.
- `load = 1` with no candidates: `o_vld <= 0`.
- `load = 0`: slot holds.

**Requester rules**
- Once valid is asserted, the requester holds key and data stable until its ready is seen.
- Valid must not drop before ready.
- The bench flags any violation.

**Reset**
- Reset values: `o_vld = 0`, `o_data = 0`, `o_idx = 0`, `ptr = 0`, lock FSM in `IDLE`.
- `o_req_rdy` is forced to all 0 while `rst = 1`.
- Reset mid-operation: a beat held in the slot is dropped, not delivered.

## Timing
- Latency: requester handshake in cycle N → `o_vld` with that beat in cycle N+1.
- Throughput: one beat per cycle while `i_rdy` is held at 1.
- `o_req_rdy` depends combinationally on `i_rdy`, `i_req_vld` and `i_req_key`. `o_vld`, `o_data` and `o_idx` are registered.
- Back-pressure with `o_vld=1` and `i_rdy=0`: all ready bits are 0 and the outputs are stable.
- Drain and refill occur in the same cycle. No bubble is inserted.

## Configuration
Macro `CM_ARB_KEY_PKT_LOCK_EN`.

When defined:
- Adds port `i_req_last` (in, `REQ_CNT`) and port `o_last` (out, 1, registered with the slot, reset 0).
- Adds FSM with states `IDLE` and `LOCK`, plus a register `lock_idx`.
- `IDLE`:
  - Grant of a beat with `last = 0` → `LOCK` and `lock_idx <= winner`.
  - Grant of a beat with `last = 1` → stays in `IDLE`.
- `LOCK`:
  - The only candidate is `lock_idx`; its key is ignored and `ptr` is not updated.
  - Grant with `last = 1` → `IDLE`, and `ptr <= lock_idx + 1` (wrapping).
- Reset → `IDLE`.

When not defined:
- No `last` ports and no FSM.
- Every beat is arbitrated independently.

## Test plan
- **Min key:** `ARB_MIN`; all four valid with keys {9, 3, 7, 3}, `ptr=0`, `i_rdy=1` → grant idx 1 (cycle N), idx 3 (N+1), idx 2 (N+2), idx 0 (N+3). Each `o_idx` appears one cycle after its grant.
- **Max key, fair ties:** `ARB_MAX`; all four keys = 5 and all requesters re-assert valid continuously → grant order 0,1,2,3,0. `ptr` wraps from 3 to 0.
- **Back-pressure:** one grant lands in the slot, then `i_rdy=0` for 3 cycles with requesters 0 and 2 valid → `o_req_rdy` = 0 and `o_data` stable for 3 cycles. On the cycle `i_rdy` returns to 1, a new grant loads in the same cycle.
- **Reset:** `rst` pulsed with `o_vld=1` holding data 0xDEADBEEF → next cycle `o_vld=0`, `o_data=0`, `ptr=0`. The held beat never appears on the output.
- **Packet lock** (macro defined, `ARB_MIN`): requester 2 sends a 3-beat packet with key 8 while requester 0 is valid with key 1 → beats from idx 2 are delivered consecutively until its `last` beat. Requester 0 is granted next, and `ptr` ends at 1.
- **Idle channel:** no valid requesters for 5 cycles with `i_rdy=1` → `o_vld=0`, `o_req_rdy=0`, and `ptr` unchanged.

Source files
------------

// File: rtl/cm_arb_key.sv
// Keyed min/max arbiter feeding one registered valid/ready output slot.
// Optional packet lock (IDLE/LOCK FSM, last ports) under `CM_ARB_KEY_PKT_LOCK_EN.
package cm_pkg;
  typedef enum logic {
    ARB_MIN = 1'b0,
    ARB_MAX = 1'b1
  } t_arb_algo;
endpackage

module cm_arb_key #(
  parameter int                REQ_CNT  = 4,
  parameter int                KEY_W    = 8,
  parameter int                DATA_W   = 32,
  parameter cm_pkg::t_arb_algo ARB_ALGO = cm_pkg::ARB_MIN,
  localparam int               IDX_W    = $clog2(REQ_CNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_CNT-1:0]              i_req_vld,
  input  logic [REQ_CNT-1:0][KEY_W-1:0]   i_req_key,
  input  logic [REQ_CNT-1:0][DATA_W-1:0]  i_req_data,
`ifdef CM_ARB_KEY_PKT_LOCK_EN
  input  logic [REQ_CNT-1:0]              i_req_last,
`endif
  output logic [REQ_CNT-1:0]              o_req_rdy,
  output logic                            o_vld,
  output logic [DATA_W-1:0]               o_data,
  output logic [IDX_W-1:0]                o_idx,
`ifdef CM_ARB_KEY_PKT_LOCK_EN
  output logic                            o_last,
`endif
  input  logic                            i_rdy
);

  localparam logic [IDX_W:0]   CNT_W    = (IDX_W+1)'(REQ_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_CNT - 1);

  logic [IDX_W-1:0]              ptr_reg;
  logic                          load;
  logic                          found;
  logic                          grant;
  logic [IDX_W-1:0]              win_idx;
  logic [KEY_W-1:0]              best_key;
  logic [REQ_CNT-1:0]            cand;
  logic [REQ_CNT-1:0][IDX_W-1:0] scan_idx;

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    return (ARB_ALGO == cm_pkg::ARB_MAX) ? (a > b) : (a < b);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  assign load  = !o_vld || i_rdy;
  assign grant = !rst && load && found;

  // scan_idx[k] is the k-th requester visited starting from ptr, with wrap
  generate
    for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_scan
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign scan_idx[gi] = (sum >= CNT_W) ? IDX_W'(sum - CNT_W) : sum[IDX_W-1:0];
    end
  endgenerate

`ifdef CM_ARB_KEY_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCK} t_lock_state;
  t_lock_state        state_reg;
  logic [IDX_W-1:0]   lock_idx_reg;
  logic [REQ_CNT-1:0] lock_mask;

  always_comb begin
    lock_mask               = '0;
    lock_mask[lock_idx_reg] = 1'b1;
  end
  assign cand = (state_reg == LOCK) ? (i_req_vld & lock_mask) : i_req_vld;
`else
  assign cand = i_req_vld;
`endif

  // Strict improvement only, so the earliest index in scan order keeps a tie
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    best_key = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (cand[scan_idx[k]] && (!found || better(i_req_key[scan_idx[k]], best_key))) begin
        found    = 1'b1;
        win_idx  = scan_idx[k];
        best_key = i_req_key[scan_idx[k]];
      end
    end
  end

  always_comb begin
    o_req_rdy = '0;
    if (grant) o_req_rdy[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld        <= 1'b0;
      o_data       <= '0;
      o_idx        <= '0;
      ptr_reg      <= '0;
`ifdef CM_ARB_KEY_PKT_LOCK_EN
      o_last       <= 1'b0;
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
`endif
    end else if (load) begin
      o_vld <= found;
      if (found) begin
        o_data <= i_req_data[win_idx];
        o_idx  <= win_idx;
`ifdef CM_ARB_KEY_PKT_LOCK_EN
        o_last <= i_req_last[win_idx];
        if (state_reg == LOCK) begin
          if (i_req_last[win_idx]) begin
            state_reg <= IDLE;
            ptr_reg   <= next_idx(lock_idx_reg);
          end
        end else begin
          ptr_reg <= next_idx(win_idx);
          if (!i_req_last[win_idx]) begin
            state_reg    <= LOCK;
            lock_idx_reg <= win_idx;
          end
        end
`else
        ptr_reg <= next_idx(win_idx);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cm_arb_key.sv
// Bench for cm_arb_key: directed scenarios plus random traffic against a
// reference model; one MIN and one MAX instance share the stimulus.
module tb_cm_arb_key;
  localparam int N = 4;
`ifdef CM_ARB_KEY_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]        vld;
  logic [N-1:0][7:0]   key;
  logic [N-1:0][31:0]  data;
  logic [N-1:0]        lst;
  logic                i_rdy;
  logic [N-1:0] rdy_a, rdy_b;
  logic         vld_a, vld_b;
  logic [31:0]  data_a, data_b;
  logic [1:0]   idx_a, idx_b;
  logic         last_a, last_b;
  bit           use_max;

  logic [N-1:0] s_rdy;
  logic         s_vld;
  logic [31:0]  s_data;
  logic [1:0]   s_idx;
  logic         s_last;
  assign s_rdy  = use_max ? rdy_b  : rdy_a;
  assign s_vld  = use_max ? vld_b  : vld_a;
  assign s_data = use_max ? data_b : data_a;
  assign s_idx  = use_max ? idx_b  : idx_a;
  assign s_last = use_max ? last_b : last_a;

  always #5 clk = ~clk;

  cm_arb_key #(.ARB_ALGO(cm_pkg::ARB_MIN)) dut_min (
    .clk(clk), .rst(rst), .i_req_vld(vld), .i_req_key(key), .i_req_data(data),
`ifdef CM_ARB_KEY_PKT_LOCK_EN
    .i_req_last(lst), .o_last(last_a),
`endif
    .o_req_rdy(rdy_a), .o_vld(vld_a), .o_data(data_a), .o_idx(idx_a), .i_rdy(i_rdy)
  );

  cm_arb_key #(.ARB_ALGO(cm_pkg::ARB_MAX)) dut_max (
    .clk(clk), .rst(rst), .i_req_vld(vld), .i_req_key(key), .i_req_data(data),
`ifdef CM_ARB_KEY_PKT_LOCK_EN
    .i_req_last(lst), .o_last(last_b),
`endif
    .o_req_rdy(rdy_b), .o_vld(vld_b), .o_data(data_b), .o_idx(idx_b), .i_rdy(i_rdy)
  );

`ifndef CM_ARB_KEY_PKT_LOCK_EN
  assign last_a = 1'b0;
  assign last_b = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr, m_idx, m_lock_idx;
  bit          m_vld, m_last, m_lock;
  logic [31:0] m_data;
  bit          e_found;
  int          e_win;
  logic [N-1:0] e_rdy;

  // Best key among eligible requesters, tie -> smallest wrapped distance from ptr
  function automatic void predict();
    int best, bd, d;
    bit load;
    e_found = 0; e_win = 0; best = 0; bd = N;
    load = !m_vld || i_rdy;
    for (int i = 0; i < N; i++)
      if (vld[i] && (!m_lock || i == m_lock_idx)) begin
        if (!e_found || (use_max ? (int'(key[i]) > best) : (int'(key[i]) < best))) best = int'(key[i]);
        e_found = 1;
      end
    if (e_found)
      for (int i = 0; i < N; i++)
        if (vld[i] && (!m_lock || i == m_lock_idx) && int'(key[i]) == best) begin
          d = (i - m_ptr + N) % N;
          if (d < bd) begin bd = d; e_win = i; end
        end
    if (!load || rst) e_found = 0;
    e_rdy = e_found ? N'(1 << e_win) : '0;
  endfunction

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = 0; m_idx = 0; m_ptr = 0; m_lock = 0; m_last = 0;
    end else if (!m_vld || i_rdy) begin
      m_vld = e_found;
      if (e_found) begin
        m_data = data[e_win]; m_idx = e_win; m_last = lst[e_win];
        if (LOCK_EN && m_lock) begin
          if (lst[e_win]) begin m_lock = 0; m_ptr = (m_lock_idx + 1) % N; end
        end else begin
          m_ptr = (e_win + 1) % N;
          if (LOCK_EN && !lst[e_win]) begin m_lock = 1; m_lock_idx = e_win; end
        end
      end
    end
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1; vld = '0; i_rdy = 1; lst = '1;
    #1; tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; vld = '1; i_rdy = 1;
    #1;
    total++;
    if (s_rdy !== 4'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0000", s_rdy); end
    tick(); tick();
    total++;
    if (s_vld !== 1'b0 || s_data !== 32'h0 || s_idx !== 2'd0) begin
      bad++; $display("FAIL reset_slot got vld=%b data=%h idx=%0d want 0/0/0", s_vld, s_data, s_idx);
    end
    rst = 0; vld = '0;
    $display("reset: done");
  endtask

  task automatic test_min_key();
    int order[4] = '{1, 3, 2, 0};
    use_max = 0;
    key = {8'd3, 8'd7, 8'd3, 8'd9};
    for (int i = 0; i < N; i++) data[i] = 32'h100 + i;
    vld = '1; i_rdy = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (s_rdy !== 4'(1 << order[c])) begin bad++; $display("FAIL min_rdy c=%0d got=%b want=%b", c, s_rdy, 4'(1 << order[c])); end
      tick();
      total++;
      if (s_vld !== 1'b1 || s_idx !== 2'(order[c]) || s_data !== 32'h100 + order[c]) begin
        bad++; $display("FAIL min_slot c=%0d got idx=%0d data=%h want idx=%0d", c, s_idx, s_data, order[c]);
      end
      $display("min_key: beat %0d idx=%0d", c, s_idx);
      vld[order[c]] = 0;
    end
  endtask

  task automatic test_max_ties();
    reset_pulse();
    use_max = 1;
    key = {4{8'd5}}; vld = '1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) data[i] = 32'h200 + c * 16 + i;
      #1;
      total++;
      if (s_rdy !== 4'(1 << (c % 4))) begin bad++; $display("FAIL max_rdy c=%0d got=%b want=%b", c, s_rdy, 4'(1 << (c % 4))); end
      tick();
      total++;
      if (s_idx !== 2'(c % 4) || s_data !== 32'h200 + c * 16 + c % 4) begin
        bad++; $display("FAIL max_slot c=%0d got idx=%0d data=%h want idx=%0d", c, s_idx, s_data, c % 4);
      end
      $display("max_ties: beat %0d idx=%0d", c, s_idx);
    end
    vld = '0;
  endtask

  task automatic test_back_pressure();
    use_max = 0;
    reset_pulse();
    vld = 4'b0001; key[0] = 8'd4; data[0] = 32'hAAAA0000;
    #1; tick();
    vld = 4'b0101; i_rdy = 0;
    key[0] = 8'd2; key[2] = 8'd6; data[0] = 32'h11110000; data[2] = 32'h22220000;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (s_rdy !== 4'b0) begin bad++; $display("FAIL bp_rdy c=%0d got=%b want=0000", c, s_rdy); end
      tick();
      total++;
      if (s_vld !== 1'b1 || s_data !== 32'hAAAA0000) begin bad++; $display("FAIL bp_hold c=%0d got data=%h want aaaa0000", c, s_data); end
      $display("back_pressure: stall %0d data=%h", c, s_data);
    end
    i_rdy = 1;
    #1;
    total++;
    if (s_rdy !== 4'b0001) begin bad++; $display("FAIL bp_refill_rdy got=%b want=0001", s_rdy); end
    tick();
    total++;
    if (s_data !== 32'h11110000 || s_idx !== 2'd0) begin bad++; $display("FAIL bp_refill got data=%h want 11110000", s_data); end
    vld = '0; tick();
  endtask

  task automatic test_reset_mid();
    vld = 4'b0010; data[1] = 32'hDEADBEEF; i_rdy = 1;
    #1; tick();
    vld = '0; i_rdy = 0;
    #1;
    total++;
    if (s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rmid_load got=%h want deadbeef", s_data); end
    rst = 1; #1; tick(); rst = 0;
    total++;
    if (s_vld !== 1'b0 || s_data !== 32'h0) begin bad++; $display("FAIL rmid_clear got vld=%b data=%h want 0/0", s_vld, s_data); end
    i_rdy = 1; vld = '1; key = '0;
    for (int i = 0; i < N; i++) data[i] = 32'h300 + i;
    #1;
    total++;
    if (s_rdy !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b want=0001", s_rdy); end
    tick();
    total++;
    if (s_data !== 32'h300) begin bad++; $display("FAIL rmid_next got=%h want 00000300", s_data); end
    $display("reset_mid: after reset data=%h", s_data);
    vld = '0; tick();
  endtask

  task automatic test_idle();
    i_rdy = 1; vld = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (s_rdy !== 4'b0) begin bad++; $display("FAIL idle_rdy c=%0d got=%b", c, s_rdy); end
      tick();
      total++;
      if (s_vld !== 1'b0) begin bad++; $display("FAIL idle_vld c=%0d got=%b want 0", c, s_vld); end
    end
    vld = '1; key = '0;
    #1;
    total++;
    if (s_rdy !== 4'b0010) begin bad++; $display("FAIL idle_ptr got=%b want=0010", s_rdy); end
    tick();
    $display("idle: ptr kept, granted idx=%0d", s_idx);
    vld = '0; tick();
  endtask

  task automatic test_random();
    for (int alg = 0; alg < 2; alg++) begin
      use_max = bit'(alg);
      reset_pulse();
      for (int c = 0; c < 250; c++) begin
        i_rdy = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++)
          if (!vld[i] && $urandom_range(0, 1) == 1) begin
            vld[i]  = 1;
            key[i]  = 8'($urandom_range(0, 3));
            data[i] = $urandom;
            lst[i]  = LOCK_EN ? ($urandom_range(0, 2) == 0) : 1'b1;
          end
        #1;
        total++;
        if (s_rdy !== e_rdy_now()) begin bad++; $display("FAIL rand_rdy alg=%0d c=%0d got=%b want=%b", alg, c, s_rdy, e_rdy); end
        tick();
        total++;
        if (s_vld !== m_vld || (m_vld && (s_data !== m_data || s_idx !== 2'(m_idx) || (LOCK_EN && s_last !== m_last)))) begin
          bad++; $display("FAIL rand_slot alg=%0d c=%0d got vld=%b idx=%0d data=%h want vld=%b idx=%0d data=%h",
                          alg, c, s_vld, s_idx, s_data, m_vld, m_idx, m_data);
        end
        $display("random: alg=%0d c=%0d rdy=%b vld=%b idx=%0d", alg, c, e_rdy, s_vld, s_idx);
        vld = vld & ~e_rdy;
      end
    end
    vld = '0;
  endtask

  function automatic logic [N-1:0] e_rdy_now();
    predict();
    return e_rdy;
  endfunction

`ifdef CM_ARB_KEY_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int order[4] = '{2, 2, 2, 0};
    use_max = 0;
    reset_pulse();
    vld = 4'b0100; key[2] = 8'd8; lst[2] = 0; data[2] = 32'hB0;
    key[0] = 8'd1; lst[0] = 1; data[0] = 32'hA0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (s_rdy !== 4'(1 << order[c])) begin bad++; $display("FAIL lock_rdy c=%0d got=%b want=%b", c, s_rdy, 4'(1 << order[c])); end
      tick();
      total++;
      if (s_idx !== 2'(order[c]) || s_last !== (c >= 2)) begin
        bad++; $display("FAIL lock_slot c=%0d got idx=%0d last=%b want idx=%0d", c, s_idx, s_last, order[c]);
      end
      $display("pkt_lock: beat %0d idx=%0d last=%b", c, s_idx, s_last);
      vld[0] = 1;
      if (c < 2) begin data[2] = 32'hB1 + c; lst[2] = (c == 1); end
      else vld[order[c]] = 0;
    end
    vld = '1; key = '0; lst = '1;
    #1;
    total++;
    if (s_rdy !== 4'b0010) begin bad++; $display("FAIL lock_ptr got=%b want=0010", s_rdy); end
    tick();
    vld = '0;
  endtask
`endif

  initial begin
    rst = 1; vld = '0; key = '0; data = '0; lst = '1; i_rdy = 1; use_max = 0;
    m_ptr = 0; m_idx = 0; m_lock_idx = 0; m_vld = 0; m_last = 0; m_lock = 0; m_data = 0;
    test_reset();
    test_min_key();
    test_max_ties();
    test_back_pressure();
    test_reset_mid();
    test_idle();
    test_random();
`ifdef CM_ARB_KEY_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
